efpga_tcdm_rr_arbiter: RTL
==========================

// Module: efpga_tcdm_rr_arbiter
// PURPOSE
// Shares one SoC-side L2 TCDM master port between N_PORTS eFPGA-side TCDM requesters, running on asic_clk_i.
// Sits between the per-port eFPGA TCDM clock-crossing interfaces and the L2 interconnect.
// Arbitration is round-robin with a lock on any pending (un-granted) request.
// An in-order ID FIFO routes each r_valid/r_rdata back to the port that issued the request.
// PARAMETERS
// N_PORTS        4      number of eFPGA-side requesters (2..8)
// AW             20     requester address width; the master address is {BASE_HI, add}
// BASE_HI        12'h1C0  upper 32-AW bits driven on m_add_o[31:AW]
// MAX_OUTST      4      ID FIFO depth = max in-flight requests (power of 2, >=2)
// PORTS
// asic_clk_i     in   1              SoC clock
// rst_n          in   1              async active-low reset
// enable_i       in   N_PORTS        per-port enable; a disabled port's req is ignored
// s_req_i        in   N_PORTS        requester req
// s_add_i        in   N_PORTS*AW     requester word address
// s_wen_i        in   N_PORTS        1=read, 0=write
// s_be_i         in   N_PORTS*4      byte enables
// s_wdata_i      in   N_PORTS*32     write data
// s_gnt_o        out  N_PORTS        grant, one-hot or zero
// s_r_valid_o    out  N_PORTS        response valid, one-hot or zero
// s_r_rdata_o    out  32             response data, broadcast to all ports
// m_req_o/m_add_o/m_wen_o/m_be_o/m_wdata_o  out 1/32/1/4/32  L2 master request
// m_gnt_i        in   1              L2 grant
// m_r_valid_i    in   1              L2 response valid
// m_r_rdata_i    in   32             L2 response data
// outst_o        out  $clog2(MAX_OUTST)+1  in-flight count
// err_o          out  1              sticky: m_r_valid_i seen with ID FIFO empty
// BEHAVIOUR
// - Reset: rr pointer=0, lock clear, FIFO empty, outst_o=0, err_o=0. All outputs 0 while s_req_i=0.
// - eligible[i] = s_req_i[i] & enable_i[i].
// - full = (outst_o==MAX_OUTST), taken from the registered count. A same-cycle pop does not bypass full.
// - Selection (combinational):
//   - If lock is set, sel = lock_id.
//   - Otherwise sel = first eligible index at or after ptr, wrapping modulo N_PORTS.
// - m_req_o = eligible[sel] & ~full. m_* payload is muxed from port sel; m_add_o = {BASE_HI, s_add_i[sel]}.
// - Handshake hs = m_req_o & m_gnt_i, combinational.
//   - s_gnt_o[sel] = hs.
//   - On hs: ptr <= sel+1 mod N_PORTS, push sel into FIFO, lock cleared.
// - Lock: when m_req_o=1 and m_gnt_i=0, lock<=1 and lock_id<=sel, holding the requester until granted.
//   - Lock also clears when s_req_i[lock_id]=0 or enable_i[lock_id]=0, i.e. the requester withdrew.
//   - While full, a locked port keeps its lock; no other port may overtake it.
// - Response: on m_r_valid_i with FIFO non-empty:
//   - s_r_valid_o[head]=1 and s_r_rdata_o=m_r_rdata_i, same cycle, zero added latency.
//   - Pop the FIFO.
// - s_r_rdata_o = m_r_rdata_i at all times, so it is valid only when qualified by s_r_valid_o.
// - m_r_valid_i with FIFO empty: response dropped, err_o<=1, held until reset.
// - Simultaneous hs and pop: count unchanged, head and tail both advance.
// - Disabling a port with requests in flight: its responses are still delivered to it.
// - Latency: request path combinational (0 cycles). Response routing is 0 cycles after m_r_valid_i.
// - Reset mid-operation: FIFO and lock flushed immediately; L2 responses still pending are counted into err_o.
// TESTING
// 1. Single port 2 reads, m_gnt_i=1, r_valid one cycle later:
//    - s_gnt_o=4'b0100 twice; s_r_valid_o[2] twice with matching rdata; outst_o peaks at 1.
// 2. All 4 ports requesting continuously, gnt=1 every cycle:
//    - Grant order 0,1,2,3,0,1.
//    - With ptr=2 at start, order is 2,3,0,1.
// 3. Port 1 requests, m_gnt_i=0 for 3 cycles, port 0 raises req in cycle 2:
//    - m_req_o stays on port 1 (lock); port 1 is granted first, then port 0.
// 4. MAX_OUTST=4, 4 grants with no r_valid:
//    - outst_o=4 and m_req_o=0 on the 5th request.
//    - One r_valid arrives: next cycle m_req_o=1.
// 5. Grants to ports 3,0,2, then three r_valids with rdata A,B,C:
//    - s_r_valid_o sequence 1000, 0001, 0100 carrying A, B, C.
// 6. m_r_valid_i pulse with FIFO empty -> err_o=1 and all s_r_valid_o=0; err_o remains 1 until rst_n low.

Source files
------------

// File: rtl/efpga_tcdm_rr_arbiter_if.sv
// rtl/efpga_tcdm_rr_arbiter_if.sv - eFPGA-side requester bundle plus the shared L2 TCDM master port
interface efpga_tcdm_rr_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int AW      = 20
);
    logic [N_PORTS-1:0]    s_req;
    logic [N_PORTS*AW-1:0] s_add;
    logic [N_PORTS-1:0]    s_wen;
    logic [N_PORTS*4-1:0]  s_be;
    logic [N_PORTS*32-1:0] s_wdata;
    logic [N_PORTS-1:0]    s_gnt;
    logic [N_PORTS-1:0]    s_r_valid;
    logic [31:0]           s_r_rdata;

    logic                  m_req;
    logic [31:0]           m_add;
    logic                  m_wen;
    logic [3:0]            m_be;
    logic [31:0]           m_wdata;
    logic                  m_gnt;
    logic                  m_r_valid;
    logic [31:0]           m_r_rdata;

    // master: the arbiter, which owns the L2 request and answers the requesters
    modport master (
        input  s_req, s_add, s_wen, s_be, s_wdata, m_gnt, m_r_valid, m_r_rdata,
        output s_gnt, s_r_valid, s_r_rdata, m_req, m_add, m_wen, m_be, m_wdata
    );

    // slave: the requesters together with the L2 interconnect
    modport slave (
        output s_req, s_add, s_wen, s_be, s_wdata, m_gnt, m_r_valid, m_r_rdata,
        input  s_gnt, s_r_valid, s_r_rdata, m_req, m_add, m_wen, m_be, m_wdata
    );
endinterface

// File: rtl/efpga_tcdm_rr_arbiter.sv
// rtl/efpga_tcdm_rr_arbiter.sv - round-robin share of one L2 TCDM port with grant lock and in-order response routing
module efpga_tcdm_rr_arbiter #(
    parameter int              N_PORTS   = 4,
    parameter int              AW        = 20,
    parameter logic [31-AW:0]  BASE_HI   = 12'h1C0,
    parameter int              MAX_OUTST = 4
) (
    input  logic                           asic_clk_i,
    input  logic                           rst_n,
    input  logic [N_PORTS-1:0]             enable,
    efpga_tcdm_rr_arbiter_if.master        bus,
    output logic [$clog2(MAX_OUTST):0]     outst,
    output logic                           err
);
    localparam int PW = $clog2(N_PORTS);
    localparam int FW = $clog2(MAX_OUTST);
    localparam int CW = FW + 1;

    logic [N_PORTS-1:0] eligible;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      rr_sel;
    logic [PW-1:0]      sel;
    logic [PW-1:0]      lock_id;
    logic               lock;
    logic               full;
    logic               hs;
    logic               pop;

    logic [PW-1:0]      id_fifo [MAX_OUTST];
    logic [FW-1:0]      wr_ptr;
    logic [FW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [PW-1:0]      head;

    assign eligible = bus.s_req & enable;
    assign full     = (count == CW'(MAX_OUTST));

    // Scan from the highest offset down so the last hit is the first eligible at or after ptr.
    always_comb begin
        rr_sel = ptr;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % N_PORTS]) begin
                rr_sel = PW'((int'(ptr) + k) % N_PORTS);
            end
        end
    end

    assign sel         = lock ? lock_id : rr_sel;
    assign bus.m_req   = eligible[sel] & ~full;
    assign hs          = bus.m_req & bus.m_gnt;

    assign bus.m_add   = bus.m_req ? {BASE_HI, bus.s_add[sel*AW +: AW]} : '0;
    assign bus.m_wen   = bus.m_req & bus.s_wen[sel];
    assign bus.m_be    = bus.m_req ? bus.s_be[sel*4 +: 4] : '0;
    assign bus.m_wdata = bus.m_req ? bus.s_wdata[sel*32 +: 32] : '0;
    assign bus.s_gnt   = hs ? (N_PORTS'(1) << sel) : '0;

    assign head          = id_fifo[rd_ptr];
    assign pop           = bus.m_r_valid & (count != '0);
    assign bus.s_r_valid = pop ? (N_PORTS'(1) << head) : '0;
    assign bus.s_r_rdata = bus.m_r_rdata;
    assign outst         = count;

    always_ff @(posedge asic_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
        end else begin
            if (hs) begin
                ptr  <= (sel == PW'(N_PORTS - 1)) ? '0 : sel + PW'(1);
                lock <= 1'b0;
            end else if (bus.m_req) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end else if (lock && !eligible[lock_id]) begin
                lock <= 1'b0;
            end
        end
    end

    // Responses arriving after a flush find the FIFO empty and are flagged through err.
    always_ff @(posedge asic_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (hs) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            if (hs && !pop) count <= count + CW'(1);
            else if (!hs && pop) count <= count - CW'(1);
            if (bus.m_r_valid && count == '0) err <= 1'b1;
        end
    end

    always_ff @(posedge asic_clk_i) begin
        if (hs) id_fifo[wr_ptr] <= sel;
    end
endmodule
